serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched.sv | 139 +++++++++++++
 tb/tb_serial_add_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// Two-requester scheduler sharing one external full-adder cell.
// Each accepted operation is added bit-serially, LSB first, over WIDTH cycles.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ0_VALID,
  input  logic             REQ1_VALID,
  output logic             REQ0_READY,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic             REQ0_CIN,
  input  logic             REQ1_CIN,
  output logic             FA_I0,
  output logic             FA_I1,
  output logic             FA_CIN,
  input  logic             FA_O,
  input  logic             FA_COUT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             RSP_ID,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             rsp_id;
  logic             last_id;

  logic             any_req;
  logic             pick1;
  logic             grant;
  logic             run_last;
  logic             rsp_take;
  op_t              sel_op;

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  assign any_req  = REQ0_VALID | REQ1_VALID;
  assign pick1    = REQ1_VALID & (~REQ0_VALID | ~last_id);
  assign grant    = RESETN & (state == IDLE) & any_req;
  assign run_last = (state == RUN) & (cnt == LAST_BIT);
  assign rsp_take = (state == DONE) & RSP_READY;

  always_comb begin
    sel_op = '0;
    unique case (1'b1)
      pick1:   sel_op = '{a: REQ1_A, b: REQ1_B, cin: REQ1_CIN};
      default: sel_op = '{a: REQ0_A, b: REQ0_B, cin: REQ0_CIN};
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = DONE;
      DONE:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      rsp_id  <= 1'b0;
      last_id <= 1'b1;
    end else begin
      if (grant) begin
        a_sr   <= sel_op.a;
        b_sr   <= sel_op.b;
        carry  <= sel_op.cin;
        cnt    <= '0;
        rsp_id <= pick1;
      end
      if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= {FA_O, sum_sr[WIDTH-1:1]};
        carry  <= FA_COUT;
        cnt    <= cnt + CW'(1);
      end
      if (rsp_take) begin
        last_id <= rsp_id;
      end
    end
  end

  assign REQ0_READY = grant & ~pick1;
  assign REQ1_READY = grant & pick1;

  assign FA_I0  = (state == RUN) & a_sr[0];
  assign FA_I1  = (state == RUN) & b_sr[0];
  assign FA_CIN = (state == RUN) & carry;

  assign RSP_VALID = (state == DONE);
  assign SUM       = sum_sr;
  assign COUT      = carry;
  assign RSP_ID    = rsp_id;
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: full-adder cell model, directed cases,
// reset abort and randomized operations against an arithmetic reference.
module tb_serial_add_sched;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         REQ0_VALID = 1'b0;
  logic         REQ1_VALID = 1'b0;
  logic         REQ0_READY;
  logic         REQ1_READY;
  logic [W-1:0] REQ0_A = '0;
  logic [W-1:0] REQ0_B = '0;
  logic [W-1:0] REQ1_A = '0;
  logic [W-1:0] REQ1_B = '0;
  logic         REQ0_CIN = 1'b0;
  logic         REQ1_CIN = 1'b0;
  logic         FA_I0;
  logic         FA_I1;
  logic         FA_CIN;
  logic         FA_O;
  logic         FA_COUT;
  logic         RSP_VALID;
  logic         RSP_READY = 1'b1;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         RSP_ID;
  logic         BUSY;

  int   n_tests = 0;
  int   n_fail = 0;
  logic last_id = 1'b1;

  serial_add_sched #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .REQ0_VALID(REQ0_VALID),
    .REQ1_VALID(REQ1_VALID),
    .REQ0_READY(REQ0_READY),
    .REQ1_READY(REQ1_READY),
    .REQ0_A(REQ0_A),
    .REQ0_B(REQ0_B),
    .REQ1_A(REQ1_A),
    .REQ1_B(REQ1_B),
    .REQ0_CIN(REQ0_CIN),
    .REQ1_CIN(REQ1_CIN),
    .FA_I0(FA_I0),
    .FA_I1(FA_I1),
    .FA_CIN(FA_CIN),
    .FA_O(FA_O),
    .FA_COUT(FA_COUT),
    .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY),
    .SUM(SUM),
    .COUT(COUT),
    .RSP_ID(RSP_ID),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  assign FA_O    = FA_I0 ^ FA_I1 ^ FA_CIN;
  assign FA_COUT = (FA_I0 & FA_I1) | (FA_I0 & FA_CIN) | (FA_I1 & FA_CIN);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    REQ0_VALID = 1'($urandom);
    REQ1_VALID = 1'($urandom);
    REQ0_A     = W'($urandom);
    REQ0_B     = W'($urandom);
    REQ1_A     = W'($urandom);
    REQ1_B     = W'($urandom);
    REQ0_CIN   = 1'($urandom);
    REQ1_CIN   = 1'($urandom);
  endtask

  // Cell drive must be idle outside RUN; no grants while busy.
  always @(negedge CLK) begin
    if (RESETN) begin
      if (!BUSY || RSP_VALID)
        chk("fa_idle", {FA_I0, FA_I1, FA_CIN}, 3'b000);
      if (BUSY)
        chk("ready_busy", {REQ0_READY, REQ1_READY}, 2'b00);
    end
  end

  // Called right after a negedge with the DUT idle.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic c1, input int hold);
    logic       g;
    logic [W:0] exp;
    int         n;
    logic       seen;
    REQ0_VALID = v0;
    REQ1_VALID = v1;
    REQ0_A = a0;
    REQ0_B = b0;
    REQ0_CIN = c0;
    REQ1_A = a1;
    REQ1_B = b1;
    REQ1_CIN = c1;
    RSP_READY = 1'b1;
    g = (v0 && v1) ? ~last_id : v1;
    if (g) exp = (W+1)'(a1) + (W+1)'(b1) + (W+1)'(c1);
    else   exp = (W+1)'(a0) + (W+1)'(b0) + (W+1)'(c0);
    #1;
    chk("ready0", REQ0_READY, !g);
    chk("ready1", REQ1_READY, g);
    @(posedge CLK);
    #1;
    chk("busy_run", BUSY, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge CLK);
      n++;
      scramble();
      if (RSP_VALID) seen = 1'b1;
    end
    chk("latency", 64'(n), 64'(W + 1));
    chk("sum", SUM, exp[W-1:0]);
    chk("cout", COUT, exp[W]);
    chk("rsp_id", RSP_ID, g);
    if (hold > 0) begin
      RSP_READY = 1'b0;
      repeat (hold) begin
        @(negedge CLK);
        scramble();
        chk("hold_valid", RSP_VALID, 1'b1);
        chk("hold_rsp", {SUM, COUT, RSP_ID}, {exp[W-1:0], exp[W], g});
        chk("hold_ready", {REQ0_READY, REQ1_READY}, 2'b00);
      end
      RSP_READY = 1'b1;
    end
    @(posedge CLK);
    #1;
    chk("idle_after", {BUSY, RSP_VALID}, 2'b00);
    last_id = g;
    @(negedge CLK);
  endtask

  task automatic rand_op();
    logic v0;
    logic v1;
    int   hold;
    v0 = 1'($urandom);
    v1 = v0 ? 1'($urandom) : 1'b1;
    hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    run_op(v0, v1, W'($urandom), W'($urandom), 1'($urandom),
           W'($urandom), W'($urandom), 1'($urandom), hold);
  endtask

  task automatic pulse_reset();
    RESETN = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    last_id = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    REQ0_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_outs",
        {BUSY, RSP_VALID, SUM, COUT, RSP_ID, FA_I0, FA_I1, FA_CIN,
         REQ0_READY, REQ1_READY}, '0);
    RESETN = 1'b1;
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    chk("rst_idle", BUSY, 1'b0);

    run_op(1, 0, 8'h5A, 8'h3C, 0, 8'h00, 8'h00, 0, 0);
    run_op(0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h01, 0, 0);
    run_op(0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 1, 0);

    pulse_reset();
    repeat (4) begin
      run_op(1, 1, W'($urandom), W'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    run_op(1, 0, 8'h81, 8'h7F, 1, 8'h00, 8'h00, 0, 5);

    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b0;
    REQ0_A = 8'h12;
    REQ0_B = 8'h34;
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b0;
    #1;
    chk("abort_outs",
        {BUSY, RSP_VALID, SUM, COUT, RSP_ID, FA_I0, FA_I1, FA_CIN,
         REQ0_READY, REQ1_READY}, '0);
    repeat (2) begin
      @(negedge CLK);
      chk("abort_norsp", RSP_VALID, 1'b0);
    end
    REQ0_VALID = 1'b0;
    RESETN = 1'b1;
    last_id = 1'b1;
    @(negedge CLK);
    chk("abort_idle", {BUSY, RSP_VALID}, 2'b00);
    run_op(0, 1, 8'h00, 8'h00, 0, 8'hC3, 8'h5E, 1, 0);

    for (int i = 0; i < 1000; i++) rand_op();

    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
